// File: rtl/rc4_phase_sequencer.sv
// RC4 phase sequencer: runs init/shuffle/decrypt sub-FSMs and arbitrates S-memory.
// Optional per-phase watchdog enabled by defining PHASE_TIMEOUT_EN.
module rc4_phase_sequencer #(
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              dec_en,
  output logic              finish,
  output logic              busy,
  output logic [1:0]        phase,
  output logic              error,
  output logic              start_init,
  output logic              start_shuffle,
  output logic              start_dec,
  input  logic              finish_init,
  input  logic              finish_shuffle,
  input  logic              finish_dec,
  input  logic              wr_en_init,
  input  logic              wr_en_shuffle,
  input  logic              wr_en_dec,
  input  logic [ADDR_W-1:0] addr_init,
  input  logic [ADDR_W-1:0] addr_shuffle,
  input  logic [ADDR_W-1:0] addr_dec,
  input  logic [DATA_W-1:0] wr_data_init,
  input  logic [DATA_W-1:0] wr_data_shuffle,
  input  logic [DATA_W-1:0] wr_data_dec,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic              mem_wr_en
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_INIT = 3'd1;
  localparam logic [2:0] S_SHUF = 3'd2;
  localparam logic [2:0] S_DEC  = 3'd3;
  localparam logic [2:0] S_GAP  = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;
  localparam logic [2:0] S_ERR  = 3'd6;

  localparam logic [1:0] N_SHUF = 2'd0;
  localparam logic [1:0] N_DEC  = 2'd1;
  localparam logic [1:0] N_DONE = 2'd2;

  logic [2:0] state_q, state_d;
  logic [1:0] nxt_q, nxt_d;
  logic       dec_q, dec_d;
  logic       tmo;

`ifdef PHASE_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          act;

  assign act = (state_q == S_INIT) ||
               (state_q == S_SHUF) ||
               (state_q == S_DEC);

  // Cleared whenever a phase is entered, so it counts cycles spent in it.
  assign cnt_d = (act && state_d == state_q) ? cnt_q + 1'b1 : '0;
  assign tmo   = act && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign error = (state_q == S_ERR);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
`else
  logic [31:0] unused_cfg;

  assign unused_cfg = 32'(TIMEOUT_CYCLES);
  assign tmo        = 1'b0;
  assign error      = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    nxt_d   = nxt_q;
    dec_d   = dec_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_INIT;
          dec_d   = dec_en;
        end
      end
      S_INIT: begin
        if (finish_init) begin
          state_d = S_GAP;
          nxt_d   = N_SHUF;
        end else if (tmo) begin
          state_d = S_ERR;
        end
      end
      S_SHUF: begin
        if (finish_shuffle) begin
          state_d = S_GAP;
          nxt_d   = dec_q ? N_DEC : N_DONE;
        end else if (tmo) begin
          state_d = S_ERR;
        end
      end
      S_DEC: begin
        if (finish_dec) begin
          state_d = S_GAP;
          nxt_d   = N_DONE;
        end else if (tmo) begin
          state_d = S_ERR;
        end
      end
      S_GAP: begin
        case (nxt_q)
          N_SHUF:  state_d = S_SHUF;
          N_DEC:   state_d = S_DEC;
          default: state_d = S_DONE;
        endcase
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      nxt_q   <= N_SHUF;
      dec_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      nxt_q   <= nxt_d;
      dec_q   <= dec_d;
    end
  end

  assign start_init    = (state_q == S_INIT);
  assign start_shuffle = (state_q == S_SHUF);
  assign start_dec     = (state_q == S_DEC);
  assign finish        = (state_q == S_DONE);
  assign busy          = (state_q != S_IDLE) && (state_q != S_ERR);

  always_comb begin
    phase = 2'd0;
    case (state_q)
      S_INIT:  phase = 2'd1;
      S_SHUF:  phase = 2'd2;
      S_DEC:   phase = 2'd3;
      default: phase = 2'd0;
    endcase
  end

  // Grant follows the state register only; q is fanned out elsewhere.
  always_comb begin
    mem_wr_en   = 1'b0;
    mem_addr    = '0;
    mem_wr_data = '0;
    unique case (1'b1)
      start_init: begin
        mem_wr_en   = wr_en_init;
        mem_addr    = addr_init;
        mem_wr_data = wr_data_init;
      end
      start_shuffle: begin
        mem_wr_en   = wr_en_shuffle;
        mem_addr    = addr_shuffle;
        mem_wr_data = wr_data_shuffle;
      end
      start_dec: begin
        mem_wr_en   = wr_en_dec;
        mem_addr    = addr_dec;
        mem_wr_data = wr_data_dec;
      end
      default: begin
        mem_wr_en   = 1'b0;
        mem_addr    = '0;
        mem_wr_data = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_rc4_phase_sequencer.sv
// Scoreboard bench for rc4_phase_sequencer: per-cycle expectations from a
// phase-timeline model; define PHASE_TIMEOUT_EN to also cover the watchdog.
module tb_rc4_phase_sequencer;

`ifdef PHASE_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 1024;
`endif

  localparam int K_IDLE = 0;
  localparam int K_ACT  = 1;
  localparam int K_GAP  = 2;
  localparam int K_DONE = 3;
  localparam int K_ERR  = 4;

  typedef struct packed {
    logic [7:0]  ctrl;
    logic [16:0] mem;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       dec_en = 1'b0;
  logic       finish, busy, error;
  logic [1:0] phase;
  logic       start_init, start_shuffle, start_dec;
  logic       finish_init = 1'b0;
  logic       finish_shuffle = 1'b0;
  logic       finish_dec = 1'b0;
  logic       wr_en_init = 1'b0;
  logic       wr_en_shuffle = 1'b0;
  logic       wr_en_dec = 1'b0;
  logic [7:0] addr_init = '0;
  logic [7:0] addr_shuffle = '0;
  logic [7:0] addr_dec = '0;
  logic [7:0] wr_data_init = '0;
  logic [7:0] wr_data_shuffle = '0;
  logic [7:0] wr_data_dec = '0;
  logic [7:0] mem_addr, mem_wr_data;
  logic       mem_wr_en;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  rc4_phase_sequencer #(
    .ADDR_W(8),
    .DATA_W(8),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .dec_en(dec_en),
    .finish(finish),
    .busy(busy),
    .phase(phase),
    .error(error),
    .start_init(start_init),
    .start_shuffle(start_shuffle),
    .start_dec(start_dec),
    .finish_init(finish_init),
    .finish_shuffle(finish_shuffle),
    .finish_dec(finish_dec),
    .wr_en_init(wr_en_init),
    .wr_en_shuffle(wr_en_shuffle),
    .wr_en_dec(wr_en_dec),
    .addr_init(addr_init),
    .addr_shuffle(addr_shuffle),
    .addr_dec(addr_dec),
    .wr_data_init(wr_data_init),
    .wr_data_shuffle(wr_data_shuffle),
    .wr_data_dec(wr_data_dec),
    .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data),
    .mem_wr_en(mem_wr_en)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] ctrl_now();
    return {finish, busy, phase, error,
            start_init, start_shuffle, start_dec};
  endfunction

  function automatic logic [16:0] mem_now();
    return {mem_wr_en, mem_addr, mem_wr_data};
  endfunction

  // Monitor: every cycle the stimulus has described is checked here.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("ctrl", 32'(ctrl_now()), 32'(e.ctrl));
      chk("mem", 32'(mem_now()), 32'(e.mem));
    end
  end

  // One clock of stimulus; p is the active phase (1..3) when kind is K_ACT.
  task automatic cyc(input int kind, input int p, input bit fin,
                     input bit st, input bit de);
    exp_t e;
    int   ph;
    @(posedge clk);
    #1;
    start  = st;
    dec_en = de;
    finish_init    = (kind == K_ACT && p == 1) ? fin : 1'($urandom_range(0, 1));
    finish_shuffle = (kind == K_ACT && p == 2) ? fin : 1'($urandom_range(0, 1));
    finish_dec     = (kind == K_ACT && p == 3) ? fin : 1'($urandom_range(0, 1));
    if ($urandom_range(0, 3) == 0) begin
      {wr_en_init, wr_en_shuffle, wr_en_dec} = 3'b111;
      addr_init    = 8'h11;
      addr_shuffle = 8'h22;
      addr_dec     = 8'h33;
    end else begin
      {wr_en_init, wr_en_shuffle, wr_en_dec} = 3'($urandom);
      addr_init    = 8'($urandom);
      addr_shuffle = 8'($urandom);
      addr_dec     = 8'($urandom);
    end
    wr_data_init    = 8'($urandom);
    wr_data_shuffle = 8'($urandom);
    wr_data_dec     = 8'($urandom);
    ph = (kind == K_ACT) ? p : 0;
    e.ctrl = {kind == K_DONE,
              kind == K_ACT || kind == K_GAP || kind == K_DONE,
              2'(ph), kind == K_ERR,
              ph == 1, ph == 2, ph == 3};
    case (ph)
      1:       e.mem = {wr_en_init, addr_init, wr_data_init};
      2:       e.mem = {wr_en_shuffle, addr_shuffle, wr_data_shuffle};
      3:       e.mem = {wr_en_dec, addr_dec, wr_data_dec};
      default: e.mem = '0;
    endcase
    sb.push_back(e);
  endtask

  task automatic rnd_cyc(input int kind, input int p, input bit fin);
    cyc(kind, p, fin, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  // Active phase lasting d+1 cycles; finish appears only on the last one.
  // stop >= 0 ends the phase early after that many cycles with no finish.
  task automatic run_phase(input int p, input int d, input int stop);
    for (int i = 0; i <= d; i++) begin
      if (stop >= 0 && i == stop) return;
      rnd_cyc(K_ACT, p, i == d);
    end
  endtask

  // mode 0: full sequence, 1: stop inside SHUF, 2: SHUF never finishes.
  task automatic run_seq(input int di, input int ds, input int dd,
                         input bit de, input int mode);
    cyc(K_IDLE, 0, 1'b0, 1'b1, de);
    run_phase(1, di, -1);
    rnd_cyc(K_GAP, 0, 1'b0);
    if (mode == 1) begin
      run_phase(2, ds, 3);
      return;
    end
    if (mode == 2) begin
      for (int i = 0; i < TO; i++) rnd_cyc(K_ACT, 2, 1'b0);
      for (int i = 0; i < 4; i++) cyc(K_ERR, 0, 1'b0, 1'b1, 1'b1);
      return;
    end
    run_phase(2, ds, -1);
    rnd_cyc(K_GAP, 0, 1'b0);
    if (de) begin
      run_phase(3, dd, -1);
      rnd_cyc(K_GAP, 0, 1'b0);
    end
    rnd_cyc(K_DONE, 0, 1'b0);
  endtask

  task automatic do_reset(input bit in_shuf);
    @(posedge clk);
    #1;
    if (in_shuf) begin
      wr_en_shuffle = 1'b1;
      addr_shuffle  = 8'h40;
      #1;
      chk("grant_before_reset", 32'(mem_now()),
          32'({1'b1, 8'h40, wr_data_shuffle}));
    end
    reset_n = 1'b0;
    #1;
    chk("async_reset_ctrl", 32'(ctrl_now()), 32'd0);
    chk("async_reset_mem", 32'(mem_now()), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    start   = 1'b0;
    for (int i = 0; i < 3; i++) cyc(K_IDLE, 0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    #1;
    chk("reset_ctrl", 32'(ctrl_now()), 32'd0);
    chk("reset_mem", 32'(mem_now()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 2; i++) cyc(K_IDLE, 0, 1'b0, 1'b0, 1'b1);

    run_seq(0, 0, 0, 1'b0, 0);
    run_seq(0, 0, 0, 1'b1, 0);
    cyc(K_IDLE, 0, 1'b0, 1'b0, 1'b0);
`ifndef PHASE_TIMEOUT_EN
    run_seq(300, 800, 0, 1'b0, 0);
    cyc(K_IDLE, 0, 1'b0, 1'b0, 1'b0);
`endif

    // Back-to-back sequences model start held high between them.
    for (int n = 0; n < 40; n++) begin
      run_seq($urandom_range(0, 12), $urandom_range(0, 12),
              $urandom_range(0, 12), 1'($urandom_range(0, 1)), 0);
      if ($urandom_range(0, 1) == 1) begin
        for (int g = $urandom_range(1, 3); g > 0; g--)
          cyc(K_IDLE, 0, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
      end
    end

    run_seq(2, 8, 0, 1'b1, 1);
    do_reset(1'b1);

`ifdef PHASE_TIMEOUT_EN
    run_seq(2, TO - 1, 1, 1'b1, 0);
    cyc(K_IDLE, 0, 1'b0, 1'b0, 1'b0);
    run_seq(1, 0, 0, 1'b0, 2);
    do_reset(1'b0);
`endif

    @(posedge clk);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
